// File: rtl/stream_pkg.sv
// Entry layout shared by the stream semaphore and its release FIFO.
// An entry is packed {tlast, tkeep, tdata}, with tdata in the low bits.
package stream_pkg;

    localparam int DATA_LSB = 0;

    function automatic int keep_lsb(input int stream_width);
        return DATA_LSB + stream_width;
    endfunction

    function automatic int last_pos(input int stream_width, input int keep_width);
        return keep_lsb(stream_width) + keep_width;
    endfunction

    function automatic int entry_width(input int stream_width, input int keep_width);
        return last_pos(stream_width, keep_width) + 1;
    endfunction

endpackage

// File: rtl/stream_release_fifo_if.sv
// AXI-Stream bundle. The sink modport is the valid-only view used where the
// producer cannot be back-pressured.
interface stream_release_fifo_if #(
    parameter int STREAM_WIDTH = 32,
    parameter int KEEP_WIDTH   = 1
);
    logic                    tvalid;
    logic                    tready;
    logic                    tlast;
    logic [STREAM_WIDTH-1:0] tdata;
    logic [KEEP_WIDTH-1:0]   tkeep;

    modport master (output tvalid, tlast, tdata, tkeep, input tready);
    modport slave  (input tvalid, tlast, tdata, tkeep, output tready);
    modport sink   (input tvalid, tlast, tdata, tkeep);
endinterface

// File: rtl/release_fifo_ram.sv
// Simple dual-port RAM: one write port, one registered read-first read port.
module release_fifo_ram #(
    parameter int ENTRIES = 127,
    parameter int WIDTH   = 34,
    parameter int ADDR_W  = 7
) (
    input  logic              aclk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data
);
    logic [WIDTH-1:0] mem [ENTRIES];

    // NOTE: the array has no reset; a resettable memory cannot map onto RAM macros.
    always_ff @(posedge aclk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        if (rd_en) rd_data <= mem[rd_addr];
    end
endmodule

// File: rtl/stream_release_fifo.sv
// Release FIFO behind the stream semaphore: buffers its valid-only stream, drives
// an AXI-Stream master, and pulses sigRelease once per beat handed downstream.
module stream_release_fifo
    import stream_pkg::*;
#(
    parameter int DEPTH        = 128,
    parameter int STREAM_WIDTH = 32,
    parameter int KEEP_WIDTH   = 1
) (
    input  logic                   aclk,
    input  logic                   resetn,
    stream_release_fifo_if.sink    s_axis,
    stream_release_fifo_if.master  m_axis,
    output logic                   sigRelease,
    output logic [$clog2(DEPTH):0] fillLevel,
    output logic                   overflow
);
    localparam int PTR_W       = $clog2(DEPTH);
    localparam int LVL_W       = PTR_W + 1;
    localparam int RAM_ENTRIES = DEPTH - 1;
    localparam int ENTRY_W     = entry_width(STREAM_WIDTH, KEEP_WIDTH);
    localparam int KEEP_LSB    = keep_lsb(STREAM_WIDTH);
    localparam int LAST_POS    = last_pos(STREAM_WIDTH, KEEP_WIDTH);

    logic               head_valid, head_from_ram, release_q, overflow_q;
    logic [ENTRY_W-1:0] head_q, ram_rd_data, head, entry_in;
    logic [LVL_W-1:0]   fill_q;
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic               handshake, ram_empty, accept, bypass, ram_wr, ram_rd;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(RAM_ENTRIES - 1)) ? '0 : p + 1'b1;
    endfunction

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        entry_in = '0;
        entry_in[DATA_LSB +: STREAM_WIDTH] = s_axis.tdata;
        entry_in[KEEP_LSB +: KEEP_WIDTH]   = s_axis.tkeep;
        entry_in[LAST_POS]                 = s_axis.tlast;
    end

    // The head entry is never empty while the RAM holds data, so fillLevel <= 1
    // means the RAM is empty.
    assign handshake = head_valid && m_axis.tready;
    assign ram_empty = (fill_q <= LVL_W'(1));
    assign accept    = s_axis.tvalid && ((fill_q < LVL_W'(DEPTH)) || handshake);
    assign bypass    = accept && (!head_valid || (handshake && ram_empty));
    assign ram_wr    = accept && !bypass;
    assign ram_rd    = handshake && !ram_empty;

    release_fifo_ram #(
        .ENTRIES (RAM_ENTRIES),
        .WIDTH   (ENTRY_W),
        .ADDR_W  (PTR_W)
    ) u_ram (
        .aclk    (aclk),
        .wr_en   (ram_wr),
        .wr_addr (wr_ptr),
        .wr_data (entry_in),
        .rd_en   (ram_rd),
        .rd_addr (rd_ptr),
        .rd_data (ram_rd_data)
    );

    // NOTE: state registers use non-blocking assignments so all updates see pre-edge values.
    always_ff @(posedge aclk or negedge resetn) begin
        if (!resetn) begin
            head_valid    <= 1'b0;
            head_from_ram <= 1'b0;
            head_q        <= '0;
            fill_q        <= '0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            release_q     <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            release_q  <= handshake;
            overflow_q <= overflow_q || (s_axis.tvalid && !accept);
            fill_q     <= fill_q + LVL_W'(accept) - LVL_W'(handshake);
            if (ram_wr) wr_ptr <= ptr_inc(wr_ptr);
            if (ram_rd) rd_ptr <= ptr_inc(rd_ptr);

            if (ram_rd) begin
                head_valid    <= 1'b1;
                head_from_ram <= 1'b1;
            end else if (bypass) begin
                head_valid    <= 1'b1;
                head_from_ram <= 1'b0;
                head_q        <= entry_in;
            end else if (handshake) begin
                head_valid <= 1'b0;
            end
        end
    end

    // Both mux sources are registers and only change on a load, so the output holds under stall.
    assign head = head_from_ram ? ram_rd_data : head_q;

    assign m_axis.tvalid = head_valid;
    assign m_axis.tdata  = head[DATA_LSB +: STREAM_WIDTH];
    assign m_axis.tkeep  = head[KEEP_LSB +: KEEP_WIDTH];
    assign m_axis.tlast  = head[LAST_POS];
    assign sigRelease    = release_q;
    assign fillLevel     = fill_q;
    assign overflow      = overflow_q;
endmodule

// File: doc/stream_release_fifo.md
Name: stream_release_fifo

Overview:
- Downstream stage of the stream semaphore.
- Accepts the semaphore's valid-only output stream (no backpressure input) into a FIFO sized to the semaphore's element limit.
- Presents the entries as an AXI-Stream master with full tready handshake.
- Pulses sigRelease once per element handed off downstream, which closes the semaphore's credit loop.

Parameters:
- DEPTH, 128: FIFO capacity in entries; power of two; must equal the semaphore's MAX_NUMBER_OF_ELEMENTS.
- STREAM_WIDTH, 32: tdata width.
- KEEP_WIDTH, 1: tkeep width.

Ports:
- aclk  in  1  clock, all logic on rising edge.
- resetn  in  1  asynchronous active-low reset.
- s_axis_tvalid  in  1  input beat present; always accepted, no tready.
- s_axis_tlast  in  1  last beat of packet.
- s_axis_tdata  in  STREAM_WIDTH  payload.
- s_axis_tkeep  in  KEEP_WIDTH  byte/lane qualifiers.
- m_axis_tvalid  out  1  output beat valid.
- m_axis_tready  in  1  downstream ready.
- m_axis_tlast  out  1  passes s_axis_tlast through.
- m_axis_tdata  out  STREAM_WIDTH  payload.
- m_axis_tkeep  out  KEEP_WIDTH  lane qualifiers.
- sigRelease  out  1  one-cycle pulse per completed output handshake.
- fillLevel  out  $clog2(DEPTH)+1  entries held, including output register.
- overflow  out  1  sticky error flag: a beat arrived while full.

Behaviour:
- Reset state (async assert, sync-safe deassert):
  - m_axis_tvalid=0, sigRelease=0, overflow=0, fillLevel=0, pointers=0.
  - m_axis_tdata/tkeep/tlast=0.
- Reset mid-operation discards all contents and takes effect immediately. No sigRelease is emitted for discarded entries; the semaphore is reset in the same domain.
- Storage structure:
  - Output register (head entry) plus RAM of DEPTH-1 entries.
  - Entry = {tlast, tkeep, tdata}, width 1+KEEP_WIDTH+STREAM_WIDTH.
  - Read and write pointers are $clog2(DEPTH)-bit and wrap naturally modulo DEPTH-1 slots via explicit compare-and-clear.
- Write rules:
  - Accept condition: s_axis_tvalid && (fillLevel<DEPTH || output handshake this cycle).
  - Full and no handshake: beat dropped, overflow set to 1, held until reset.
- Bypass latency:
  - Applies when the output register is empty, or is being consumed and the RAM is empty.
  - The input beat loads directly into the output register.
  - Beat valid in cycle 0 gives m_axis_tvalid=1 in cycle 1.
- Non-bypass:
  - The beat is written to RAM.
  - On an output handshake with RAM non-empty, the output register reloads from RAM at the same edge.
  - Throughput is 1 beat/cycle sustained, no bubbles.
- Output hold: while m_axis_tvalid && !m_axis_tready, m_axis_* stay stable (AXIS rule).
- sigRelease:
  - Registered; high in cycle N+1 for each handshake in cycle N.
  - Back-to-back handshakes give a continuous high level, one count per cycle.
- fillLevel:
  - +1 on an accepted write, -1 on a handshake, unchanged when both occur.
  - Never exceeds DEPTH, never underflows.
- Order preserved; tlast/tkeep travel with their data unmodified.

Decomposition:
- Shared package (stream_pkg):
  - Entry layout constants for tlast/tkeep/tdata field offsets.
  - Entry width function.
  - The semaphore uses the same package for its skid packing.
- One sub-module, release_fifo_ram: simple dual-port RAM, one write and one registered read port, DEPTH-1 entries, entry width parameterised.
- Control, output register and counters stay in stream_release_fifo.

Test Plan:
- Single beat, empty FIFO, m_axis_tready=1:
  - Beat data 0xCAFE0001 in cycle 0 gives m_axis_tvalid=1 with that data in cycle 1.
  - sigRelease=1 in cycle 2 only.
  - fillLevel 0→1→0.
- Fill to DEPTH=128 with m_axis_tready=0, then 1 further beat:
  - fillLevel=128.
  - overflow=1 and stays 1.
  - Draining outputs exactly 128 beats in order 0..127.
  - The extra beat is absent.
- Full FIFO with concurrent input and output handshake each cycle for 50 cycles:
  - No overflow; fillLevel stays 128.
  - Outputs in order.
  - sigRelease high for 50 consecutive cycles, offset by 1.
- Random m_axis_tready (50%) with bursts of tlast-marked packets of lengths 1, 3 and 16:
  - Output stream identical to input including tkeep and tlast.
  - Count of sigRelease pulses equals handshake count.
- Hold check:
  - m_axis_tready=0 for 5 cycles with tvalid=1: tdata/tkeep/tlast unchanged.
  - No sigRelease pulse in that window.
- Assert resetn low asynchronously mid-drain with 40 entries held:
  - Outputs go to reset values immediately.
  - After release, the first new beat appears with latency 1.
  - No stale data is emitted.
